// File: rtl/masked_pkg.sv
// Shared constants and index helpers for the masked AND gadget.
package masked_pkg;

    localparam int MAX_NSHARES = 8;

    function automatic int nrand(input int n);
        return n * (n - 1) / 2;
    endfunction

    // Lexicographic index of the unordered share pair {i,j}, i != j.
    function automatic int pair_idx(input int i, input int j, input int n);
        int lo;
        int hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        return lo * (2 * n - lo - 1) / 2 + (hi - lo - 1);
    endfunction

    // Low bit of share/word i on a bus packed as i*w +: w.
    function automatic int share_lo(input int i, input int w);
        return i * w;
    endfunction

endpackage

// File: rtl/masked_and_pipe_dom_term_reg.sv
// One registered DOM term; each partial product gets its own flop so no
// two product terms meet combinationally before a register.
module dom_term_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/masked_and_pipe.sv
// Pipelined DOM-indep masked AND, z = x & y over NSHARES shares of WIDTH lanes.
// Optional output refresh stage: define MASKED_AND_OUT_REFRESH_EN (adds port rr).
module masked_and_pipe
    import masked_pkg::*;
#(
    parameter int  NSHARES = 3,
    parameter int  WIDTH   = 1,
    localparam int NRAND   = nrand(NSHARES)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NSHARES*WIDTH-1:0]   x,
    input  logic [NSHARES*WIDTH-1:0]   y,
    input  logic [NRAND*WIDTH-1:0]     r,
`ifdef MASKED_AND_OUT_REFRESH_EN
    input  logic [(NSHARES-1)*WIDTH-1:0] rr,
`endif
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [NSHARES*WIDTH-1:0]   z,
    output logic                       out_valid,
    input  logic                       out_ready
);

    // Handshake: a beat transfers on a rising edge where valid & ready are both
    // high; a producer holds valid and data stable until the transfer, and
    // in_ready may depend combinationally on out_ready.

    logic [WIDTH-1:0]         t [NSHARES][NSHARES];
    logic [NSHARES*WIDTH-1:0] z_next;
    logic [NSHARES*WIDTH-1:0] z2;
    logic                     s1_load;
    logic                     s2_load;
    logic                     down_ready;
    logic                     v1;
    logic                     v2;

    assign s1_load = in_valid & in_ready;
    assign s2_load = v1 & (!v2 | down_ready);
    assign in_ready = !v1 | !v2 | down_ready;

    for (genvar i = 0; i < NSHARES; i++) begin : g_row
        for (genvar j = 0; j < NSHARES; j++) begin : g_col
            logic [WIDTH-1:0] d;
            if (i == j) begin : g_diag
                assign d = x[share_lo(i, WIDTH) +: WIDTH] & y[share_lo(j, WIDTH) +: WIDTH];
            end else begin : g_cross
                assign d = (x[share_lo(i, WIDTH) +: WIDTH] & y[share_lo(j, WIDTH) +: WIDTH])
                         ^ r[share_lo(pair_idx(i, j, NSHARES), WIDTH) +: WIDTH];
            end
            dom_term_reg #(.WIDTH(WIDTH)) u_term (
                .clk  (clk),
                .rst  (rst),
                .load (s1_load),
                .d    (d),
                .q    (t[i][j])
            );
        end
    end

    // Compression only ever combines already-registered terms.
    always_comb begin
        z_next = '0;
        for (int i = 0; i < NSHARES; i++) begin
            for (int j = 0; j < NSHARES; j++) begin
                z_next[i*WIDTH +: WIDTH] = z_next[i*WIDTH +: WIDTH] ^ t[i][j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            z2 <= '0;
        end else begin
            v1 <= s1_load | (v1 & !s2_load);
            v2 <= s2_load | (v2 & !down_ready);
            if (s2_load) begin
                z2 <= z_next;
            end
        end
    end

`ifdef MASKED_AND_OUT_REFRESH_EN
    logic [NSHARES*WIDTH-1:0] zr_next;
    logic [NSHARES*WIDTH-1:0] z3;
    logic                     s3_load;
    logic                     v3;

    assign down_ready = !v3 | out_ready;
    assign s3_load    = v2 & down_ready;

    // Each rr word lands in share 0 and one other share, so the unmasked value is kept.
    always_comb begin
        zr_next = z2;
        for (int i = 1; i < NSHARES; i++) begin
            zr_next[i*WIDTH +: WIDTH] = zr_next[i*WIDTH +: WIDTH] ^ rr[(i-1)*WIDTH +: WIDTH];
            zr_next[WIDTH-1:0]        = zr_next[WIDTH-1:0] ^ rr[(i-1)*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v3 <= 1'b0;
            z3 <= '0;
        end else begin
            v3 <= s3_load | (v3 & !out_ready);
            if (s3_load) begin
                z3 <= zr_next;
            end
        end
    end

    assign z         = z3;
    assign out_valid = v3;
`else
    assign down_ready = out_ready;
    assign z          = z2;
    assign out_valid  = v2;
`endif

endmodule

// File: tb/tb_masked_and_pipe.sv
// Self-checking bench for masked_and_pipe (3-share/1-bit and 2-share/8-bit instances).
module tb_masked_and_pipe;

`ifdef MASKED_AND_OUT_REFRESH_EN
    localparam int       LAT  = 3;
    localparam logic [2:0] EXP1 = 3'b111;
    localparam logic [2:0] EXP2 = 3'b010;
`else
    localparam int       LAT  = 2;
    localparam logic [2:0] EXP1 = 3'b001;
    localparam logic [2:0] EXP2 = 3'b100;
`endif

    logic        clk;
    logic        rst;

    logic [2:0]  x3, y3, r3, z3;
    logic        iv3, ir3, ov3, or3;
    logic [15:0] x2, y2, z2;
    logic [7:0]  r2;
    logic        iv2, ir2, ov2, or2;
`ifdef MASKED_AND_OUT_REFRESH_EN
    logic [1:0]  rr3;
    logic [7:0]  rr2;
`endif

    int n_checks;
    int n_fail;
    logic [7:0] exp_q[$];
    logic [2:0] exp3_q[$];

    masked_and_pipe #(.NSHARES(3), .WIDTH(1)) u3 (
        .clk       (clk),
        .rst       (rst),
        .x         (x3),
        .y         (y3),
        .r         (r3),
`ifdef MASKED_AND_OUT_REFRESH_EN
        .rr        (rr3),
`endif
        .in_valid  (iv3),
        .in_ready  (ir3),
        .z         (z3),
        .out_valid (ov3),
        .out_ready (or3)
    );

    masked_and_pipe #(.NSHARES(2), .WIDTH(8)) u2 (
        .clk       (clk),
        .rst       (rst),
        .x         (x2),
        .y         (y2),
        .r         (r2),
`ifdef MASKED_AND_OUT_REFRESH_EN
        .rr        (rr2),
`endif
        .in_valid  (iv2),
        .in_ready  (ir2),
        .z         (z2),
        .out_valid (ov2),
        .out_ready (or2)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Share-level DOM reference for 3 shares: z_i = x_i y_i ^ sum_{j!=i} (x_i y_j ^ r_{pair(i,j)})
    function automatic logic [2:0] model3(input logic [2:0] xa, input logic [2:0] ya,
                                          input logic [2:0] ra);
        logic [2:0] zz;
        int kk;
        zz = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (i == j) begin
                    zz[i] = zz[i] ^ (xa[i] & ya[i]);
                end else begin
                    kk = (i + j == 1) ? 0 : ((i + j == 2) ? 1 : 2);
                    zz[i] = zz[i] ^ (xa[i] & ya[j]) ^ ra[kk];
                end
            end
        end
`ifdef MASKED_AND_OUT_REFRESH_EN
        zz[0] = zz[0] ^ rr3[0] ^ rr3[1];
        zz[1] = zz[1] ^ rr3[0];
        zz[2] = zz[2] ^ rr3[1];
`endif
        return zz;
    endfunction

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op3(input logic [2:0] xa, input logic [2:0] ya, input logic [2:0] ra,
                           output logic ir_seen, output logic [2:0] zo, output int lat);
        x3  = xa;
        y3  = ya;
        r3  = ra;
        iv3 = 1'b1;
        or3 = 1'b1;
        @(negedge clk);
        ir_seen = ir3;
        tick();
        iv3 = 1'b0;
        x3  = 3'($urandom);
        r3  = 3'($urandom);
        lat = 1;
        while (lat <= 10) begin
            @(negedge clk);
            if (ov3 === 1'b1) break;
            tick();
            lat++;
        end
        zo = z3;
        tick();
    endtask

    // Tests
    task automatic test_reset();
        rst = 1'b1;
        iv3 = 1'b0; iv2 = 1'b0; or3 = 1'b1; or2 = 1'b1;
        x3 = '0; y3 = '0; r3 = '0; x2 = '0; y2 = '0; r2 = '0;
        repeat (2) tick();
        @(negedge clk);
        n_checks++; if (ov3 !== 1'b0) begin n_fail++; $display("FAIL reset_ov3: got %b want 0", ov3); end
        n_checks++; if (z3 !== 3'b000) begin n_fail++; $display("FAIL reset_z3: got %b want 000", z3); end
        n_checks++; if (ir3 !== 1'b1) begin n_fail++; $display("FAIL reset_ir3: got %b want 1", ir3); end
        n_checks++; if (ov2 !== 1'b0) begin n_fail++; $display("FAIL reset_ov2: got %b want 0", ov2); end
        n_checks++; if (z2 !== 16'h0) begin n_fail++; $display("FAIL reset_z2: got %h want 0000", z2); end
        n_checks++; if (ir2 !== 1'b1) begin n_fail++; $display("FAIL reset_ir2: got %b want 1", ir2); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_masking();
        logic       irs;
        logic [2:0] zo, xa, ya, ra;
        int         lat;
        run_op3(3'b001, 3'b111, 3'b000, irs, zo, lat);
        n_checks++; if (irs !== 1'b1) begin n_fail++; $display("FAIL op1_in_ready: got %b want 1", irs); end
        n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL op1_latency: got %0d want %0d", lat, LAT); end
        n_checks++; if (zo !== EXP1) begin n_fail++; $display("FAIL op1_z: got %b want %b", zo, EXP1); end
        n_checks++; if ((^zo) !== 1'b1) begin n_fail++; $display("FAIL op1_xor: got %b want 1", ^zo); end
        run_op3(3'b001, 3'b111, 3'b101, irs, zo, lat);
        n_checks++; if (zo !== EXP2) begin n_fail++; $display("FAIL op2_z: got %b want %b", zo, EXP2); end
        n_checks++; if ((^zo) !== 1'b1) begin n_fail++; $display("FAIL op2_xor: got %b want 1", ^zo); end
        ra = 3'($urandom);
        run_op3(3'b011, 3'b111, ra, irs, zo, lat);
        n_checks++; if ((^zo) !== 1'b0) begin n_fail++; $display("FAIL op3_xor: got %b want 0", ^zo); end
        for (int n = 0; n < 8; n++) begin
            xa = 3'($urandom); ya = 3'($urandom); ra = 3'($urandom);
            run_op3(xa, ya, ra, irs, zo, lat);
            n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL rnd3_latency: got %0d want %0d", lat, LAT); end
            n_checks++; if (zo !== model3(xa, ya, ra)) begin n_fail++; $display("FAIL rnd3_z: got %b want %b", zo, model3(xa, ya, ra)); end
            n_checks++; if ((^zo) !== ((^xa) & (^ya))) begin n_fail++; $display("FAIL rnd3_xor: got %b want %b", ^zo, (^xa) & (^ya)); end
        end
    endtask

    task automatic test_back_to_back();
        int          got;
        logic [15:0] xa, ya;
        logic [7:0]  e, act;
        exp_q.delete();
        got = 0;
        or2 = 1'b1;
        for (int c = 0; c < 1000 + LAT; c++) begin
            iv2 = (c < 1000);
            xa = 16'($urandom);
            ya = 16'($urandom);
            x2 = xa; y2 = ya; r2 = 8'($urandom);
`ifdef MASKED_AND_OUT_REFRESH_EN
            rr2 = 8'($urandom);
`endif
            @(negedge clk);
            n_checks++; if (ir2 !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready: cycle %0d got %b want 1", c, ir2); end
            n_checks++; if (ov2 !== (c >= LAT)) begin n_fail++; $display("FAIL b2b_out_valid: cycle %0d got %b want %b", c, ov2, c >= LAT); end
            if (ov2 === 1'b1 && exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = z2[7:0] ^ z2[15:8];
                got++;
                n_checks++; if (act !== e) begin n_fail++; $display("FAIL b2b_result: cycle %0d got %h want %h", c, act, e); end
            end
            if (iv2 && ir2) exp_q.push_back((xa[7:0] ^ xa[15:8]) & (ya[7:0] ^ ya[15:8]));
            tick();
        end
        iv2 = 1'b0;
        n_checks++; if (got !== 1000) begin n_fail++; $display("FAIL b2b_count: got %0d want 1000", got); end
        n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL b2b_leftover: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        logic [2:0] xa, ya, ra, e;
        int acc, got, waited;
        exp3_q.delete();
        or3 = 1'b0;
        acc = 0;
        waited = 0;
        while (waited < 10) begin
            xa = 3'($urandom); ya = 3'($urandom); ra = 3'($urandom);
            x3 = xa; y3 = ya; r3 = ra; iv3 = 1'b1;
            @(negedge clk);
            if (ir3 !== 1'b1) break;
            exp3_q.push_back(model3(xa, ya, ra));
            acc++;
            tick();
            waited++;
        end
        n_checks++; if (acc !== LAT) begin n_fail++; $display("FAIL bp_accepts: got %0d want %0d", acc, LAT); end
        for (int h = 0; h < 5; h++) begin
            @(posedge clk);
            #1;
            x3 = 3'($urandom); y3 = 3'($urandom); r3 = 3'($urandom);
            @(negedge clk);
            n_checks++; if (ir3 !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: hold %0d got %b want 0", h, ir3); end
            n_checks++; if (ov3 !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid: hold %0d got %b want 1", h, ov3); end
            if (exp3_q.size() > 0) begin
                n_checks++; if (z3 !== exp3_q[0]) begin n_fail++; $display("FAIL bp_z_hold: hold %0d got %b want %b", h, z3, exp3_q[0]); end
            end
        end
        iv3 = 1'b0;
        or3 = 1'b1;
        got = 0;
        for (int c = 0; c < 12 && got < LAT; c++) begin
            #1;
            if (ov3 === 1'b1 && exp3_q.size() > 0) begin
                e = exp3_q.pop_front();
                got++;
                n_checks++; if (z3 !== e) begin n_fail++; $display("FAIL bp_release_z: result %0d got %b want %b", got, z3, e); end
            end
            @(negedge clk);
        end
        n_checks++; if (got !== LAT) begin n_fail++; $display("FAIL bp_release_count: got %0d want %0d", got, LAT); end
        tick();
    endtask

    task automatic test_reset_mid_op();
        or3 = 1'b0;
        for (int n = 0; n < LAT; n++) begin
            x3 = 3'($urandom); y3 = 3'b111; r3 = 3'($urandom); iv3 = 1'b1;
            tick();
        end
        iv3 = 1'b0;
        @(negedge clk);
        n_checks++; if (ov3 !== 1'b1) begin n_fail++; $display("FAIL rstmid_full: got %b want 1", ov3); end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (ov3 !== 1'b0) begin n_fail++; $display("FAIL rstmid_ov: got %b want 0", ov3); end
        n_checks++; if (z3 !== 3'b000) begin n_fail++; $display("FAIL rstmid_z: got %b want 000", z3); end
        n_checks++; if (ir3 !== 1'b1) begin n_fail++; $display("FAIL rstmid_ir: got %b want 1", ir3); end
        or3 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            @(negedge clk);
            n_checks++; if (ov3 !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale: cycle %0d got %b want 0", c, ov3); end
        end
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
`ifdef MASKED_AND_OUT_REFRESH_EN
        rr3 = 2'b11;
        rr2 = 8'h00;
`endif
        test_reset();
        test_masking();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
